// File: rtl/rob.sv
`default_nettype none
// ============================================================================
//  Module   : rob (with mips_core_pkg)
//  Purpose  : In-order-retire reorder buffer for the out-of-order MIPS core.
//             Optional same-cycle complete-to-commit forwarding at the head
//             is enabled by defining ROB_COMPLETE_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================

package mips_core_pkg;

    typedef struct packed {
        logic [2:0]  inst_type;
        logic [5:0]  reg_dest;
        logic        jump_reg;
        logic [31:0] mem_dest;
        logic [31:0] value;
        logic        ready;
    } rob_entry;

endpackage

module rob
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [2:0]                  alloc_inst_type,
    input  logic [5:0]                  alloc_reg_dest,
    input  logic                        alloc_jump_reg,
    output logic [TAG_W-1:0]            alloc_tag,
    input  logic                        complete_valid,
    input  logic [TAG_W-1:0]            complete_tag,
    input  logic [31:0]                 complete_value,
    input  logic [31:0]                 complete_mem_dest,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [$bits(rob_entry)-1:0] commit_entry,
    output logic [TAG_W:0]              count
);

    localparam logic [TAG_W:0] C_FULL_COUNT = (TAG_W+1)'(DEPTH);

    rob_entry             entries_q [DEPTH];
    rob_entry             entries_d [DEPTH];
    logic [DEPTH-1:0]     occupied_q, occupied_d;
    logic [TAG_W-1:0]     head_q, head_d;
    logic [TAG_W-1:0]     tail_q, tail_d;
    logic [TAG_W:0]       count_q, count_d;

    logic                 w_alloc_fire;
    logic                 w_complete_fire;
    logic                 w_commit_fire;
    logic                 w_bypass_hit;
    rob_entry             w_head_entry;

`ifdef ROB_COMPLETE_BYPASS_EN
    assign w_bypass_hit = complete_valid && (complete_tag == head_q) && occupied_q[head_q];
`else
    assign w_bypass_hit = 1'b0;
`endif

    always_comb begin
        w_head_entry = entries_q[head_q];
        if (w_bypass_hit) begin
            w_head_entry.value    = complete_value;
            w_head_entry.mem_dest = complete_mem_dest;
            w_head_entry.ready    = 1'b1;
        end
    end

    // alloc_ready looks only at registered occupancy, never at a same-cycle commit
    assign alloc_ready  = (count_q != C_FULL_COUNT);
    assign alloc_tag    = tail_q;
    assign commit_valid = occupied_q[head_q] && w_head_entry.ready;
    assign commit_entry = w_head_entry;
    assign count        = count_q;

    assign w_alloc_fire    = alloc_valid && alloc_ready;
    assign w_complete_fire = complete_valid && occupied_q[complete_tag];
    assign w_commit_fire   = commit_valid && commit_ready;

    always_comb begin
        entries_d  = entries_q;
        occupied_d = occupied_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush) begin
            entries_d  = '{default: '0};
            occupied_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            // A forwarded head completion that retires this cycle needs no write-back
            if (w_complete_fire && !(w_bypass_hit && w_commit_fire)) begin
                entries_d[complete_tag].value    = complete_value;
                entries_d[complete_tag].mem_dest = complete_mem_dest;
                entries_d[complete_tag].ready    = 1'b1;
            end

            if (w_alloc_fire) begin
                entries_d[tail_q].inst_type = alloc_inst_type;
                entries_d[tail_q].reg_dest  = alloc_reg_dest;
                entries_d[tail_q].jump_reg  = alloc_jump_reg;
                entries_d[tail_q].mem_dest  = '0;
                entries_d[tail_q].value     = '0;
                entries_d[tail_q].ready     = 1'b0;
                occupied_d[tail_q]          = 1'b1;
                tail_d                      = tail_q + 1'b1;
            end

            if (w_commit_fire) begin
                occupied_d[head_q] = 1'b0;
                head_d             = head_q + 1'b1;
            end

            case ({w_alloc_fire, w_commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q  <= '{default: '0};
            occupied_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            entries_q  <= entries_d;
            occupied_q <= occupied_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob
//  Purpose  : Table-driven self-checking bench for the reorder buffer.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_rob;
    import mips_core_pkg::*;

`ifdef ROB_COMPLETE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [2:0]  alloc_inst_type;
    logic [5:0]  alloc_reg_dest;
    logic        alloc_jump_reg;
    logic [2:0]  alloc_tag;
    logic        complete_valid;
    logic [2:0]  complete_tag;
    logic [31:0] complete_value;
    logic [31:0] complete_mem_dest;
    logic        commit_valid;
    logic        commit_ready;
    logic [$bits(rob_entry)-1:0] commit_entry;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    rob #(.DEPTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_inst_type   (alloc_inst_type),
        .alloc_reg_dest    (alloc_reg_dest),
        .alloc_jump_reg    (alloc_jump_reg),
        .alloc_tag         (alloc_tag),
        .complete_valid    (complete_valid),
        .complete_tag      (complete_tag),
        .complete_value    (complete_value),
        .complete_mem_dest (complete_mem_dest),
        .commit_valid      (commit_valid),
        .commit_ready      (commit_ready),
        .commit_entry      (commit_entry),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, av;
        logic [5:0]  rd;
        logic        cv;
        logic [2:0]  ct;
        logic [31:0] cval;
        logic        cr;
        logic        chk;
        logic        ar;
        logic [2:0]  at;
        logic        cmv;
        logic [3:0]  cnt;
        logic [31:0] eval;
        logic [5:0]  erd;
        logic        ez;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic f, logic av, logic [5:0] rd,
                                logic cv, logic [2:0] ct, logic [31:0] cval, logic cr,
                                logic chk, logic ar, logic [2:0] at, logic cmv,
                                logic [3:0] cnt, logic [31:0] eval, logic [5:0] erd,
                                logic ez);
        vec_t v;
        v.rst = r; v.flush = f; v.av = av; v.rd = rd; v.cv = cv; v.ct = ct;
        v.cval = cval; v.cr = cr; v.chk = chk; v.ar = ar; v.at = at; v.cmv = cmv;
        v.cnt = cnt; v.eval = eval; v.erd = erd; v.ez = ez;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic av, logic [5:0] rd,
                         logic cv, logic [2:0] ct, logic [31:0] cval, logic cr);
        rst               = r;
        flush             = f;
        alloc_valid       = av;
        alloc_reg_dest    = rd;
        alloc_inst_type   = 3'd2;
        alloc_jump_reg    = 1'b0;
        complete_valid    = cv;
        complete_tag      = ct;
        complete_value    = cval;
        complete_mem_dest = ~cval;
        commit_ready      = cr;
    endtask

    task automatic check_outputs(string tag, logic ar, logic [2:0] at, logic cmv,
                                 logic [3:0] cnt, logic [31:0] eval, logic [5:0] erd,
                                 logic ez);
        rob_entry ce;
        ce = rob_entry'(commit_entry);
        check({tag, ".alloc_ready"},  32'(alloc_ready),  32'(ar));
        check({tag, ".alloc_tag"},    32'(alloc_tag),    32'(at));
        check({tag, ".commit_valid"}, 32'(commit_valid), 32'(cmv));
        check({tag, ".count"},        32'(count),        32'(cnt));
        if (cmv) begin
            check({tag, ".value"},    ce.value,          eval);
            check({tag, ".mem_dest"}, ce.mem_dest,       ~eval);
            check({tag, ".reg_dest"}, 32'(ce.reg_dest),  32'(erd));
        end
        if (ez) check({tag, ".entry_zero"}, 32'(commit_entry != '0), 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 3'd0, 32'd0, 1'b0);

        //               rst f  av rd   cv ct cval       cr chk ar at cmv cnt eval      erd ez
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0,         0, 0,  0, 0, 0,  0, 0,         0,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         0, 1,  1, 0, 0,  0, 0,         0,  1));
        vecs.push_back(mk(0, 0, 1, 5,   0, 0, 0,         0, 1,  1, 0, 0,  0, 0,         0,  0));
        vecs.push_back(mk(0, 0, 1, 6,   0, 0, 0,         0, 1,  1, 1, 0,  1, 0,         0,  0));
        vecs.push_back(mk(0, 0, 1, 7,   0, 0, 0,         0, 1,  1, 2, 0,  2, 0,         0,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         1, 1,  1, 3, 0,  3, 0,         0,  0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 1, 32'hAAAA,  0, 1,  1, 3, 0,  3, 0,         0,  0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 0, 32'h1234,  0, 1,  1, 3, BYP,3, 32'h1234,  5,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         1, 1,  1, 3, 1,  3, 32'h1234,  5,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         1, 1,  1, 3, 1,  2, 32'hAAAA,  6,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         1, 1,  1, 3, 0,  1, 0,         0,  0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0, 0, 1, 6'(10 + i), 0, 0, 0, 0, 1, 1, 3'(3 + i), 0,
                              4'(1 + i), 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 20,  1, 2, 32'h5555,  0, 1,  0, 2, BYP,8, 32'h5555,  7,  0));
        vecs.push_back(mk(0, 0, 1, 20,  0, 0, 0,         1, 1,  0, 2, 1,  8, 32'h5555,  7,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         0, 1,  1, 2, 0,  7, 0,         0,  0));
        vecs.push_back(mk(0, 1, 1, 30,  1, 3, 32'h1,     1, 1,  1, 2, BYP,7, 32'h1,     10, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         0, 1,  1, 0, 0,  0, 0,         0,  1));
        vecs.push_back(mk(0, 0, 0, 0,   1, 5, 32'h77,    1, 1,  1, 0, 0,  0, 0,         0,  1));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0,         1, 1,  1, 0, 0,  0, 0,         0,  1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].av, vecs[i].rd,
                  vecs[i].cv, vecs[i].ct, vecs[i].cval, vecs[i].cr);
            #1;
            if (vecs[i].chk)
                check_outputs($sformatf("v%0d", i), vecs[i].ar, vecs[i].at, vecs[i].cmv,
                              vecs[i].cnt, vecs[i].eval, vecs[i].erd, vecs[i].ez);
        end

        // Head completion with retire ready: same-cycle commit only when forwarding
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 6'd9, 1'b0, 3'd0, 32'd0, 1'b0);
        #1 check_outputs("bp_alloc", 1'b1, 3'd0, 1'b0, 4'd0, 32'd0, 6'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 3'd0, 32'hBEEF, 1'b1);
        #1 check_outputs("bp_complete", 1'b1, 3'd1, BYP, 4'd1, 32'hBEEF, 6'd9, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 3'd0, 32'd0, 1'b1);
        #1 check_outputs("bp_next", 1'b1, 3'd1, !BYP, BYP ? 4'd0 : 4'd1, 32'hBEEF, 6'd9, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 3'd0, 32'd0, 1'b0);
        #1 check_outputs("bp_drained", 1'b1, 3'd1, 1'b0, 4'd0, 32'd0, 6'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
